// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_WORD_W sets the word width; the FETCH_DELAY_SLOT_EN macro (used in fetch_stage) selects delay-slot behaviour.
`ifndef FETCH_WORD_W
`define FETCH_WORD_W 32
`endif

package fetch_stage_pkg;

    localparam int unsigned WORD_W = `FETCH_WORD_W;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [WORD_W-1:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] seq_pc(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // The link register value is the address after the delay slot.
    function automatic logic [WORD_W-1:0] link_pc(input logic [WORD_W-1:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage and memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module fetch_stage_ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic [WORD_W-1:0] inst_in,
    input  logic [WORD_W-1:0] pc_in,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc8,
    output logic              valid
);

    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc8_q, pc8_d;
    logic              valid_q, valid_d;

    // Load has priority over bubble; a bubble keeps the last PC so only inst/valid change.
    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (load) begin
            inst_d  = inst_in;
            pc_d    = pc_in;
            pc8_d   = link_pc(pc_in);
            valid_d = 1'b1;
        end else if (bubble) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0000_0000;
            pc8_q   <= 32'h0000_0008;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
        end
    end

    assign inst  = inst_q;
    assign pc    = pc_q;
    assign pc8   = pc8_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, one-entry skid buffer and IF/ID register.
// Define FETCH_DELAY_SLOT_EN for delay-slot semantics; otherwise the post-branch instruction is squashed.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] ifid_inst,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_pc8,
    output logic              ifid_valid
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
    logic [WORD_W-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_W-1:0] skid_pc_q, skid_pc_d;

    logic              redir_s;
    logic              advance_s;
    logic              req_s;
    logic              ld_s;
    logic              bub_s;
    logic [WORD_W-1:0] ld_inst_s;
    logic [WORD_W-1:0] ld_pc_s;
    logic [WORD_W-1:0] next_pc_s;

    // A same-cycle redirect wins over a pending one, which wins over sequential flow.
    always_comb begin
        redir_s = redirect_valid & ~stall;
        if (redir_s) begin
            next_pc_s = redirect_pc;
        end else if (pend_valid_q) begin
            next_pc_s = pend_pc_q;
        end else begin
            next_pc_s = seq_pc(pc_q);
        end
    end

    // Next-state, PC update and IF/ID control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q | redir_s;
        pend_pc_d    = redir_s ? redirect_pc : pend_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        advance_s    = 1'b0;
        req_s        = 1'b0;
        ld_s         = 1'b0;
        bub_s        = 1'b0;
        ld_inst_s    = imem.imem_rdata;
        ld_pc_s      = pc_q;

        case (state_q)
            ST_FETCH: begin
                req_s = 1'b1;
                if (imem.imem_ready) begin
                    if (!stall) begin
                        advance_s = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
                        ld_s = 1'b1;
`else
                        if (redir_s) begin
                            bub_s = 1'b1;
                        end else begin
                            ld_s = 1'b1;
                        end
`endif
                    end else begin
                        skid_inst_d = imem.imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    bub_s = ~stall;
`ifndef FETCH_DELAY_SLOT_EN
                    // The request cannot be withdrawn, so its wrong-path data is discarded later.
                    if (redir_s) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_FETCH;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    advance_s = 1'b1;
                    ld_inst_s = skid_inst_q;
                    ld_pc_s   = skid_pc_q;
                    state_d   = ST_FETCH;
`ifdef FETCH_DELAY_SLOT_EN
                    ld_s = 1'b1;
`else
                    if (redir_s) begin
                        bub_s = 1'b1;
                    end else begin
                        ld_s = 1'b1;
                    end
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                req_s = 1'b1;
                bub_s = ~stall;
                if (imem.imem_ready) begin
                    advance_s = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (advance_s) begin
            pc_d         = next_pc_s;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch-control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Gate with rst_n so no request is presented while reset is asserted.
    assign imem.imem_req  = req_s & rst_n;
    assign imem.imem_addr = pc_q;

    fetch_stage_ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld_s),
        .bubble  (bub_s),
        .inst_in (ld_inst_s),
        .pc_in   (ld_pc_s),
        .inst    (ifid_inst),
        .pc      (ifid_pc),
        .pc8     (ifid_pc8),
        .valid   (ifid_valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Owns the PC, drives the instruction-memory request handshake, and holds the IF/ID pipeline register whose instruction word feeds the ID-stage decoder. Accepts stall from the hazard unit and redirect from ID-stage branch/jump resolution. Buffers one returned instruction when ID is stalled.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held with `imem_addr` stable until `imem_ready`
- imem_addr  out  32  fetch byte address (= PC)
- imem_rdata  in  32  instruction word; valid in the cycle `imem_ready`=1
- imem_ready  in  1  request completes this cycle
- stall  in  1  hold IF/ID and PC (from hazard unit)
- redirect_valid  in  1  taken branch/jump resolved in ID; sampled only when `stall`=0
- redirect_pc  in  32  redirect target
- ifid_inst  out  32  instruction to decoder; 0 (nop) when bubble
- ifid_pc  out  32  PC of `ifid_inst`
- ifid_pc8  out  32  `ifid_pc`+8 (link value)
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH (request outstanding for PC), HOLD (instruction captured in skid buffer, no request), DROP (outstanding request is wrong-path; data discarded).
- FETCH: `imem_req`=1. On `imem_ready`: if `stall`=0, load IF/ID {rdata, pc, valid=1}, PC←next; if `stall`=1, capture rdata/pc into skid buffer, go HOLD. No `imem_ready` and `stall`=0 → IF/ID loads bubble (inst=0, valid=0).
- HOLD: `imem_req`=0. When `stall`=0: IF/ID←skid buffer, PC←next, go FETCH.
- next PC: pending redirect target if set, else PC+4 (mod 2^32).
- Redirect (`redirect_valid` & !`stall`): target latched in `redir_pend`; consumed at next PC update. A new redirect overwrites a pending one.
- In-flight request is never aborted; address stays stable until `imem_ready`.
- `stall` and `redirect_valid` both high: redirect ignored.
- Branch-delay-slot semantics: see Configuration.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, `imem_req`=0 while `rst_n`=0, `ifid_inst`=0, `ifid_pc`=0, `ifid_pc8`=8, `ifid_valid`=0, `redir_pend` cleared, skid empty.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=RESET_PC.
- `imem_ready` tied 1, no stall: one instruction per cycle; fetch at cycle t appears on `ifid_*` at t+1.
- Redirect at cycle t with `imem_ready`=1: PC=`redirect_pc` at t+1.
- Redirect while request outstanding: target applied when that request completes.
- Reset mid-operation: all state cleared immediately, outstanding request forgotten (memory must accept dropped request).
- `ifid_pc8` registered together with `ifid_pc`.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined: MIPS delay slot; the instruction completing on or after the redirect cycle (sequential successor of the branch) enters IF/ID normally; DROP unused.
- Undefined: that instruction is squashed — loaded as bubble if completing in the redirect cycle, else state→DROP and its data discarded; skid buffer content at redirect also squashed.

## Structure
- Shared package/header: `RESET_PC` default, NOP encoding (32'h0), state encodings FETCH/HOLD/DROP, word width macro.
- One sub-module: `ifid_reg` (IF/ID register with load/bubble/hold controls, async active-low reset).

## Test plan
- Reset release, `imem_ready`=1, rdata=PC-derived: `ifid_pc` sequence 0x3000, 0x3004, 0x3008; `ifid_pc8`=0x3008 with pc 0x3000.
- `stall`=1 for 3 cycles at `ifid_pc`=0x3004: IF/ID holds 0x3004, state HOLD with 0x3008 buffered, `imem_req`=0; after release 0x3008 then 0x300C, none lost or repeated.
- DS on, redirect to 0x3100 when `ifid_pc`=0x3010: IF/ID shows 0x3014 then 0x3100.
- DS off, same stimulus: IF/ID shows bubble (`ifid_valid`=0, inst=0) then 0x3100.
- `imem_ready` low 2 cycles with redirect mid-wait: `imem_addr` stable, `ifid_valid`=0 during wait, target fetched after completion.
- `rst_n` pulsed low mid-stall with pending redirect: outputs return to reset values; fetch restarts at 0x3000.
